// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program counter and instruction-fetch sequencer for the single-issue core.
// The PC is fetched over a level req/ack memory handshake. The fetched word
// is held on Instruccion for decode and for the next-PC offset selector. That
// selector returns Incremento (4 or a branch offset), and the PC advances by
// that amount. A misaligned target or a missing ack stops the unit in a
// sticky fault state. Only reset clears this state.
//
// Sequencer: FETCH -> WAIT -> EXEC -> FETCH ...
//            WAIT  -> FAULT on timeout, EXEC -> FAULT on misaligned target.
//
// Parameters
//   RESET_PC    PC value loaded on reset.
//   MAX_WAIT    WAIT cycles without imem_ack before a timeout fault (1..255).
//
// Ports
//   clk          core clock, rising edge
//   reset        synchronous, active-high reset (priority over all inputs)
//   Incremento   PC increment from the next-PC offset selector
//   stall        hold the current instruction in EXEC
//   imem_req     instruction-memory request (level)
//   imem_addr    fetch address, always equal to PC
//   imem_ack     read data valid this cycle
//   imem_rdata   fetched instruction word
//   Instruccion  current instruction to decode / selector
//   inst_valid   Instruccion valid (EXEC)
//   PC           current program counter
//   fault        sticky fault flag
//   fault_code   00 none, 01 misaligned target, 10 fetch timeout
//   retired      retired-instruction count
//
// Optional feature macro: FETCH_RETIRE_CNT_EN
//   When defined, retired counts EXEC->FETCH transitions (wraps at 2^32).
//   When undefined, retired is tied to zero and no counter is built.
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Incremento,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruccion,
  output logic        inst_valid,
  output logic [31:0] PC,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INSN      = 32'h0000_0013;
  localparam logic [7:0]  MAX_WAIT_CNT  = 8'(MAX_WAIT);
  localparam logic [1:0]  CODE_NONE     = 2'b00;
  localparam logic [1:0]  CODE_MISALIGN = 2'b01;
  localparam logic [1:0]  CODE_TIMEOUT  = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] insn_q, insn_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        fault_q, fault_d;
  logic [1:0]  fault_code_q, fault_code_d;

  logic [31:0] next_pc;
  logic [7:0]  wait_cnt_inc;

  // Candidate target; wraps modulo 2^32, so negative offsets just work.
  assign next_pc      = pc_q + Incremento;
  assign wait_cnt_inc = wait_cnt_q + 8'd1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      insn_q       <= NOP_INSN;
      wait_cnt_q   <= 8'd0;
      fault_q      <= 1'b0;
      fault_code_q <= CODE_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      insn_q       <= insn_d;
      wait_cnt_q   <= wait_cnt_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    insn_d       = insn_q;
    wait_cnt_d   = wait_cnt_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;

    unique case (state_q)
      ST_FETCH: begin
        // The wait counter starts from zero on every entry to WAIT.
        state_d    = ST_WAIT;
        wait_cnt_d = 8'd0;
      end

      ST_WAIT: begin
        if (imem_ack) begin
          insn_d  = imem_rdata;
          state_d = ST_EXEC;
        end else begin
          wait_cnt_d = wait_cnt_inc;
          // An ack in the last allowed cycle still wins over the timeout.
          if (wait_cnt_inc == MAX_WAIT_CNT) begin
            fault_d      = 1'b1;
            fault_code_d = CODE_TIMEOUT;
            state_d      = ST_FAULT;
          end
        end
      end

      ST_EXEC: begin
        if (!stall) begin
          if (next_pc[1:0] != 2'b00) begin
            // PC stays on the offending instruction for post-mortem.
            fault_d      = 1'b1;
            fault_code_d = CODE_MISALIGN;
            state_d      = ST_FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
        end
      end

      ST_FAULT: begin
        // Terminal until reset.
      end

      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The request is masked during reset so the pins show their reset values
  // while reset is held, even though the register already sits in FETCH.
  assign imem_req    = ((state_q == ST_FETCH) || (state_q == ST_WAIT)) && !reset;
  assign imem_addr   = pc_q;
  assign PC          = pc_q;
  assign Instruccion = insn_q;
  assign inst_valid  = (state_q == ST_EXEC);
  assign fault       = fault_q;
  assign fault_code  = fault_code_q;

  // ---------------------------------------------------------------------------
  // Retired-instruction counter (optional)
  // ---------------------------------------------------------------------------
`ifdef FETCH_RETIRE_CNT_EN
  logic [31:0] retired_q, retired_d;
  logic        retire_evt;

  // Same condition as the EXEC->FETCH transition above.
  assign retire_evt = (state_q == ST_EXEC) && !stall && (next_pc[1:0] == 2'b00);

  always_comb begin
    retired_d = retired_q;
    if (retire_evt) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= 32'd0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`else
  assign retired = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Drives pc_fetch_unit with directed scenarios followed by randomized
// traffic. A transaction-level model predicts every output, and the outputs
// are compared once per cycle on the falling edge. Literal expectations
// cross-check the model at key points.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          MAX_WAIT = 16;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  localparam int PH_FETCH = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_EXEC  = 2;
  localparam int PH_FAULT = 3;

  logic        clk = 1'b0;
  logic        reset_r = 1'b1;
  logic [31:0] incr_r = 32'd4;
  logic        stall_r = 1'b0;
  logic        ack_r = 1'b0;
  logic [31:0] rdata_r = 32'd0;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] Instruccion;
  logic        inst_valid;
  logic [31:0] PC;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] retired;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  int          m_phase;
  int          m_waited;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        m_fault;
  logic [1:0]  m_code;
  logic [31:0] m_ret;

  pc_fetch_unit #(
    .RESET_PC (RESET_PC),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk         (clk),
    .reset       (reset_r),
    .Incremento  (incr_r),
    .stall       (stall_r),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (ack_r),
    .imem_rdata  (rdata_r),
    .Instruccion (Instruccion),
    .inst_valid  (inst_valid),
    .PC          (PC),
    .fault       (fault),
    .fault_code  (fault_code),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of the specification's rules, applied to the inputs present
  // at this rising edge.
  task automatic model_step();
    logic [31:0] tgt;
    if (reset_r) begin
      m_phase  = PH_FETCH;
      m_waited = 0;
      m_pc     = RESET_PC;
      m_inst   = NOP;
      m_fault  = 1'b0;
      m_code   = 2'b00;
      m_ret    = 32'd0;
    end else if (m_phase == PH_FETCH) begin
      m_phase  = PH_WAIT;
      m_waited = 0;
    end else if (m_phase == PH_WAIT) begin
      if (ack_r) begin
        m_inst  = rdata_r;
        m_phase = PH_EXEC;
      end else begin
        m_waited++;
        if (m_waited == MAX_WAIT) begin
          m_fault = 1'b1;
          m_code  = 2'b10;
          m_phase = PH_FAULT;
        end
      end
    end else if (m_phase == PH_EXEC && !stall_r) begin
      tgt = m_pc + incr_r;
      if (tgt % 4 != 0) begin
        m_fault = 1'b1;
        m_code  = 2'b01;
        m_phase = PH_FAULT;
      end else begin
        m_pc    = tgt;
        m_ret   = m_ret + 32'd1;
        m_phase = PH_FETCH;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_ret;
`ifdef FETCH_RETIRE_CNT_EN
    exp_ret = m_ret;
`else
    exp_ret = 32'd0;
`endif
    chk("imem_req",    {31'd0, imem_req},
        {31'd0, ((m_phase == PH_FETCH) || (m_phase == PH_WAIT)) && !reset_r});
    chk("imem_addr",   imem_addr, m_pc);
    chk("PC",          PC, m_pc);
    chk("Instruccion", Instruccion, m_inst);
    chk("inst_valid",  {31'd0, inst_valid}, {31'd0, m_phase == PH_EXEC});
    chk("fault",       {31'd0, fault}, {31'd0, m_fault});
    chk("fault_code",  {30'd0, fault_code}, {30'd0, m_code});
    chk("retired",     retired, exp_ret);
  endtask

  // Drive inputs at the falling edge, advance the model on the rising edge,
  // then compare on the next falling edge.
  task automatic tick(input logic rst, input logic stl, input logic [31:0] inc,
                      input logic ack, input logic [31:0] rd);
    reset_r = rst;
    stall_r = stl;
    incr_r  = inc;
    ack_r   = ack;
    rdata_r = rd;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic fetch_ok(input logic [31:0] rd);
    tick(1'b0, 1'b0, 32'd4, 1'b0, 32'd0);  // FETCH -> WAIT
    tick(1'b0, 1'b0, 32'd4, 1'b1, rd);     // ack in first WAIT cycle
  endtask

  function automatic logic [31:0] pick_inc();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 6)      return 32'd4;
    else if (sel < 9) return $urandom() & 32'hFFFF_FFFC;
    else              return $urandom();
  endfunction

  initial begin
    logic [31:0] exp_ret1;
    logic [31:0] inc_hold;
    logic        rst;
    logic        stl;

    m_phase = PH_FETCH; m_waited = 0; m_pc = RESET_PC; m_inst = NOP;
    m_fault = 1'b0; m_code = 2'b00; m_ret = 32'd0;

    @(negedge clk);
    tick(1'b1, 1'b0, 32'd4, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd4, 1'b1, 32'h1234_5678);
    chk("pin_rst_req",   {31'd0, imem_req}, 32'd0);
    chk("pin_rst_inst",  Instruccion, 32'h0000_0013);

    // Basic fetch: ack in first WAIT cycle, then advance by 4.
    tick(1'b0, 1'b0, 32'd4, 1'b0, 32'd0);
    chk("pin_addr0",     imem_addr, 32'h0);
    chk("pin_req_wait",  {31'd0, imem_req}, 32'd1);
    tick(1'b0, 1'b0, 32'd4, 1'b1, 32'h0000_0013);
    chk("pin_valid_2cyc", {31'd0, inst_valid}, 32'd1);
    tick(1'b0, 1'b0, 32'd4, 1'b0, 32'd0);
    chk("pin_pc4",       PC, 32'h4);
`ifdef FETCH_RETIRE_CNT_EN
    exp_ret1 = 32'd1;
`else
    exp_ret1 = 32'd0;
`endif
    chk("pin_retired1",  retired, exp_ret1);

    // Walk up to PC=0x10, then branch back by 8.
    for (int i = 0; i < 3; i++) begin
      fetch_ok(32'h0000_0013);
      tick(1'b0, 1'b0, 32'd4, 1'b0, 32'd0);
    end
    chk("pin_pc10",      PC, 32'h10);
    fetch_ok(32'h0000_0063);
    tick(1'b0, 1'b0, 32'hFFFF_FFF8, 1'b0, 32'd0);
    chk("pin_branch_pc", PC, 32'h8);
    chk("pin_branch_nf", {31'd0, fault}, 32'd0);

    // Stall for three EXEC cycles.
    fetch_ok(32'hCAFE_0093);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 32'd4, $urandom_range(0, 1) == 1, $urandom());
      chk("pin_stall_pc",   PC, 32'h8);
      chk("pin_stall_inst", Instruccion, 32'hCAFE_0093);
      chk("pin_stall_vld",  {31'd0, inst_valid}, 32'd1);
    end
    tick(1'b0, 1'b0, 32'd4, 1'b0, 32'd0);
    chk("pin_unstall_pc", PC, 32'hC);

    // Misaligned target.
    tick(1'b1, 1'b0, 32'd4, 1'b0, 32'd0);
    fetch_ok(32'h0000_0013);
    tick(1'b0, 1'b0, 32'h0000_0006, 1'b0, 32'd0);
    chk("pin_mis_fault", {31'd0, fault}, 32'd1);
    chk("pin_mis_code",  {30'd0, fault_code}, 32'd1);
    chk("pin_mis_pc",    PC, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 32'd4, 1'b1, $urandom());
      chk("pin_mis_req", {31'd0, imem_req}, 32'd0);
    end

    // Wrap-around at the top of the address space.
    tick(1'b1, 1'b0, 32'd4, 1'b0, 32'd0);
    fetch_ok(32'h0000_0013);
    tick(1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'd0);
    chk("pin_pc_top",    PC, 32'hFFFF_FFFC);
    fetch_ok(32'h0000_0013);
    tick(1'b0, 1'b0, 32'd4, 1'b0, 32'd0);
    chk("pin_wrap_pc",   PC, 32'h0);
    chk("pin_wrap_nf",   {31'd0, fault}, 32'd0);
    tick(1'b0, 1'b0, 32'd4, 1'b0, 32'd0);
    chk("pin_wrap_addr", imem_addr, 32'h0);

    // Timeout: one FETCH cycle, then 16 WAIT cycles without ack.
    tick(1'b1, 1'b0, 32'd4, 1'b0, 32'd0);
    tick(1'b0, 1'b0, 32'd4, 1'b0, 32'd0);
    for (int i = 0; i < MAX_WAIT - 1; i++) tick(1'b0, 1'b0, 32'd4, 1'b0, 32'd0);
    chk("pin_to_early",  {31'd0, fault}, 32'd0);
    tick(1'b0, 1'b0, 32'd4, 1'b0, 32'd0);
    chk("pin_to_fault",  {31'd0, fault}, 32'd1);
    chk("pin_to_code",   {30'd0, fault_code}, 32'd2);
    tick(1'b1, 1'b0, 32'd4, 1'b1, 32'hABCD_0000);
    chk("pin_rstack_pc",  PC, RESET_PC);
    chk("pin_rstack_vld", {31'd0, inst_valid}, 32'd0);
    chk("pin_rstack_flt", {31'd0, fault}, 32'd0);

    // Reset wins over an ack in WAIT.
    tick(1'b0, 1'b0, 32'd4, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd4, 1'b1, 32'hABCD_0000);
    chk("pin_rstwait_inst", Instruccion, 32'h0000_0013);
    tick(1'b0, 1'b0, 32'd4, 1'b0, 32'd0);

    // Randomized traffic; Incremento is held for the whole EXEC residency.
    inc_hold = 32'd4;
    for (int i = 0; i < 4000; i++) begin
      if (m_phase == PH_FAULT) rst = ($urandom_range(0, 9) == 0);
      else                     rst = ($urandom_range(0, 299) == 0);
      if (m_phase != PH_EXEC) inc_hold = pick_inc();
      stl = ($urandom_range(0, 2) == 0);
      tick(rst, stl, inc_hold, $urandom_range(0, 1) == 1, $urandom());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
